// File: rtl/dwt53_row_lift.sv
// Two-row horizontal reversible 5/3 lifting DWT with symmetric extension at both line ends.
// Optional DWT_BYPASS_EN adds a per-line bypass input that forwards raw even/odd samples.
module dwt53_row_lift #(
    parameter int IN_W       = 11,
    parameter int COEF_W     = 12,
    parameter int LINE_LEN   = 256,
    parameter int TILE_LINES = 128,
    parameter int SAMPLE_PER = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_tile,
    input  logic                     en_line,
`ifdef DWT_BYPASS_EN
    input  logic                     bypass,
`endif
    input  logic signed [IN_W-1:0]   image_in1,
    input  logic signed [IN_W-1:0]   image_in2,
    output logic signed [COEF_W-1:0] coef_l1,
    output logic signed [COEF_W-1:0] coef_h1,
    output logic signed [COEF_W-1:0] coef_l2,
    output logic signed [COEF_W-1:0] coef_h2,
    output logic                     out_valid,
    output logic                     out_last,
    output logic                     tile_done,
    output logic                     line_err
);

    localparam int DW = IN_W + 2;
    localparam int CW = $clog2(LINE_LEN + 1);
    localparam int LW = (TILE_LINES > 1) ? $clog2(TILE_LINES) : 1;
    localparam int PW = (SAMPLE_PER > 1) ? $clog2(SAMPLE_PER) : 1;

    typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_t;

    function automatic logic signed [DW-1:0] high_pass(input logic signed [IN_W-1:0] a,
                                                      input logic signed [IN_W-1:0] b,
                                                      input logic signed [IN_W-1:0] c);
        logic signed [DW-1:0] sum;
        sum = DW'(a) + DW'(c);
        return DW'(b) - (sum >>> 1);
    endfunction

    // One extra bit: two full-scale d values plus rounding need 14 bits.
    function automatic logic signed [DW:0] low_pass(input logic signed [IN_W-1:0] a,
                                                   input logic signed [DW-1:0]   dl,
                                                   input logic signed [DW-1:0]   dr);
        logic signed [DW:0] t;
        t = (DW+1)'(dl) + (DW+1)'(dr) + (DW+1)'(2);
        return (DW+1)'(a) + (t >>> 2);
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic [LW-1:0]     line_cnt_q;
    logic              en_line_q, err_q, err_d;
    logic              rise, in_line, cap, last_smp, fire, byp;
    logic              p_valid_q, p_last_q, p_first_q;
    logic              out_valid_q, out_last_q, tile_q;

    logic signed [IN_W-1:0]   x_in [2];
    logic signed [IN_W-1:0]   he_q [2];
    logic signed [IN_W-1:0]   ho_q [2];
    logic signed [IN_W-1:0]   pa_q [2];
    logic signed [IN_W-1:0]   pb_q [2];
    logic signed [IN_W-1:0]   pc_q [2];
    logic signed [DW-1:0]     dp_q [2];
    logic signed [DW-1:0]     d    [2];
    logic signed [DW:0]       s    [2];
    logic signed [COEF_W-1:0] l_q  [2];
    logic signed [COEF_W-1:0] h_q  [2];

    assign x_in[0] = image_in1;
    assign x_in[1] = image_in2;

`ifdef DWT_BYPASS_EN
    logic byp_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_q <= 1'b0;
        end else if (cap && state_q == StIdle) begin
            byp_q <= bypass;
        end
    end
    assign byp = byp_q;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        rise     = en_line && !en_line_q;
        in_line  = (state_q == StFill) || (state_q == StRun);
        cap      = en_tile && en_line && (ph_q == '0) && ((state_q == StIdle && rise) || in_line);
        last_smp = (cnt_q == CW'(LINE_LEN - 1));
        // Pair n launches on capture of x[2n+2], the final pair on x[LINE_LEN-1].
        fire     = cap && ((!cnt_q[0] && cnt_q != '0) || last_smp);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ph_d    = '0;
        if (en_tile && en_line) begin
            ph_d = (ph_q == PW'(SAMPLE_PER - 1)) ? '0 : ph_q + PW'(1);
        end
        if (!en_tile) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cap) begin
                        state_d = StFill;
                        cnt_d   = CW'(1);
                    end
                end
                StFill, StRun: begin
                    if (!en_line) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else if (cap) begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = last_smp ? StFlush : StRun;
                    end
                end
                StFlush: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ph_q      <= '0;
            en_line_q <= 1'b0;
            err_q     <= 1'b0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_first_q <= 1'b0;
            for (int r = 0; r < 2; r++) begin
                he_q[r] <= '0;
                ho_q[r] <= '0;
                pa_q[r] <= '0;
                pb_q[r] <= '0;
                pc_q[r] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            en_line_q <= en_line;
            err_q     <= err_d;
            p_valid_q <= fire;
            if (fire) begin
                p_last_q  <= last_smp;
                p_first_q <= (cnt_q == CW'(2));
            end
            for (int r = 0; r < 2; r++) begin
                if (cap) begin
                    if (!cnt_q[0]) he_q[r] <= x_in[r];
                    else           ho_q[r] <= x_in[r];
                end
                if (fire) begin
                    pa_q[r] <= he_q[r];
                    pb_q[r] <= last_smp ? x_in[r] : ho_q[r];
                    pc_q[r] <= last_smp ? he_q[r] : x_in[r];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            d[r] = high_pass(pa_q[r], pb_q[r], pc_q[r]);
            s[r] = low_pass(pa_q[r], p_first_q ? d[r] : dp_q[r], d[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tile_q      <= 1'b0;
            line_cnt_q  <= '0;
            for (int r = 0; r < 2; r++) begin
                dp_q[r] <= '0;
                l_q[r]  <= '0;
                h_q[r]  <= '0;
            end
        end else begin
            out_valid_q <= p_valid_q;
            out_last_q  <= p_valid_q && p_last_q;
            tile_q      <= p_valid_q && p_last_q && en_tile &&
                           (line_cnt_q == LW'(TILE_LINES - 1));
            if (!en_tile) begin
                line_cnt_q <= '0;
            end else if (p_valid_q && p_last_q) begin
                line_cnt_q <= (line_cnt_q == LW'(TILE_LINES - 1)) ? '0 : line_cnt_q + LW'(1);
            end
            if (p_valid_q) begin
                for (int r = 0; r < 2; r++) begin
                    dp_q[r] <= d[r];
                    l_q[r]  <= byp ? COEF_W'(pa_q[r]) : s[r][COEF_W-1:0];
                    h_q[r]  <= byp ? COEF_W'(pb_q[r]) : d[r][COEF_W-1:0];
                end
            end
        end
    end

    assign coef_l1   = l_q[0];
    assign coef_h1   = h_q[0];
    assign coef_l2   = l_q[1];
    assign coef_h2   = h_q[1];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign tile_done = tile_q;
    assign line_err  = err_q;

endmodule

// File: tb/tb_dwt53_row_lift.sv
// Randomized and directed bench for dwt53_row_lift against a plain-arithmetic 5/3 lifting model.
module tb_dwt53_row_lift;

    localparam int IN_W   = 11;
    localparam int COEF_W = 12;
    localparam int L      = 256;
    localparam int TL     = 128;
    localparam int SP     = 2;
    localparam int NEVER  = 1 << 20;

    typedef struct {
        int l1, h1, l2, h2;
        bit last, tile;
        int cyc, n;
    } pair_t;

    logic clk = 1'b0;
    logic reset, en_tile, en_line, bypass;
    logic signed [IN_W-1:0]   image_in1, image_in2;
    logic signed [COEF_W-1:0] coef_l1, coef_h1, coef_l2, coef_h2;
    logic out_valid, out_last, tile_done, line_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;
    int tile_pulses = 0;
    int model_lines = 0;
    pair_t exp_q[$];
    pair_t mon_e;
    int obs_l1[L/2], obs_h1[L/2], obs_l2[L/2], obs_h2[L/2];

    dwt53_row_lift #(
        .IN_W(IN_W), .COEF_W(COEF_W), .LINE_LEN(L), .TILE_LINES(TL), .SAMPLE_PER(SP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en_tile(en_tile),
        .en_line(en_line),
`ifdef DWT_BYPASS_EN
        .bypass(bypass),
`endif
        .image_in1(image_in1),
        .image_in2(image_in2),
        .coef_l1(coef_l1),
        .coef_h1(coef_h1),
        .coef_l2(coef_l2),
        .coef_h2(coef_h2),
        .out_valid(out_valid),
        .out_last(out_last),
        .tile_done(tile_done),
        .line_err(line_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int t12(input int v);
        logic signed [COEF_W-1:0] b;
        b = v[COEF_W-1:0];
        return int'(b);
    endfunction

    // Reference: d[n] = x[2n+1] - floor((x[2n]+x[2n+2])/2), s[n] = x[2n] + floor((d[n-1]+d[n]+2)/4)
    task automatic lift(input int x[L], output int lo[L/2], output int hi[L/2]);
        int xr, dl;
        for (int n = 0; n < L/2; n++) begin
            xr = (2*n + 2 < L) ? x[2*n+2] : x[L-2];
            hi[n] = x[2*n+1] - ((x[2*n] + xr) >>> 1);
        end
        for (int n = 0; n < L/2; n++) begin
            dl = (n == 0) ? hi[0] : hi[n-1];
            lo[n] = x[2*n] + ((dl + hi[n] + 2) >>> 2);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                pulses++;
                if (tile_done === 1'b1) tile_pulses++;
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_cycle", cyc, mon_e.cyc);
                    check("coef_l1", int'(coef_l1), mon_e.l1);
                    check("coef_h1", int'(coef_h1), mon_e.h1);
                    check("coef_l2", int'(coef_l2), mon_e.l2);
                    check("coef_h2", int'(coef_h2), mon_e.h2);
                    check("out_last", int'(out_last), int'(mon_e.last));
                    check("tile_done", int'(tile_done), int'(mon_e.tile));
                    obs_l1[mon_e.n] = int'(coef_l1);
                    obs_h1[mon_e.n] = int'(coef_h1);
                    obs_l2[mon_e.n] = int'(coef_l2);
                    obs_h2[mon_e.n] = int'(coef_h2);
                end
            end else if (reset === 1'b0 && (out_last === 1'b1 || tile_done === 1'b1)) begin
                check("flag_without_valid", 1, 0);
            end
        end
    end

    // pattern: 0 zero, 1 ramp/alternating, 2 alternating/down-ramp, other random.
    task automatic send_line(input int pattern, input int nsamp, input int tile_drop_at,
                             input int reset_at);
        int x1[L], x2[L];
        int lo1[L/2], hi1[L/2], lo2[L/2], hi2[L/2];
        int n;
        pair_t e;
        for (int i = 0; i < L; i++) begin
            case (pattern)
                0: begin x1[i] = 0; x2[i] = 0; end
                1: begin x1[i] = i - 128; x2[i] = (i % 2 == 0) ? 10 : -10; end
                2: begin x1[i] = (i % 2 == 0) ? 10 : -10; x2[i] = 127 - i; end
                default: begin
                    x1[i] = int'($urandom_range(2047, 0)) - 1024;
                    x2[i] = int'($urandom_range(2047, 0)) - 1024;
                end
            endcase
        end
        lift(x1, lo1, hi1);
        lift(x2, lo2, hi2);
        pulses = 0;
        for (int i = 0; i < nsamp; i++) begin
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("reset_flags", int'({out_valid, out_last, tile_done, line_err}), 0);
                check("reset_coefs", int'(|{coef_l1, coef_h1, coef_l2, coef_h2}), 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                exp_q.delete();
                model_lines = 0;
                break;
            end
            if (i == tile_drop_at) en_tile = 1'b0;
            en_line = 1'b1;
            image_in1 = (i < L) ? x1[i][IN_W-1:0] : IN_W'($urandom);
            image_in2 = (i < L) ? x2[i][IN_W-1:0] : IN_W'($urandom);
            @(posedge clk);
            #1;
            if (en_tile && i < L && ((i % 2 == 0 && i >= 2) || i == L - 1)) begin
                n = (i == L - 1) ? L/2 - 1 : i/2 - 1;
                e.l1 = t12(lo1[n]);
                e.h1 = t12(hi1[n]);
                e.l2 = t12(lo2[n]);
                e.h2 = t12(hi2[n]);
                e.last = (n == L/2 - 1);
                e.tile = 1'b0;
                if (e.last) begin
                    e.tile = (model_lines == TL - 1);
                    model_lines = e.tile ? 0 : model_lines + 1;
                end
                e.cyc = cyc + 1;
                e.n = n;
                exp_q.push_back(e);
            end
            repeat (SP - 1) begin
                @(posedge clk);
                #1;
            end
        end
        en_line = 1'b0;
        image_in1 = '0;
        image_in2 = '0;
        if (tile_drop_at < nsamp) model_lines = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        en_tile = 1'b1;
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        en_tile = 1'b0;
        en_line = 1'b0;
        bypass = 1'b0;
        image_in1 = '0;
        image_in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", int'({out_valid, out_last, tile_done, line_err}), 0);
        reset = 1'b0;
        en_tile = 1'b1;
        @(posedge clk);
        #1;

        send_line(0, L, NEVER, NEVER);
        check("zero_pulses", pulses, L/2);
        check("zero_l1_last", obs_l1[L/2-1], 0);

        send_line(1, L, NEVER, NEVER);
        check("ramp_d_mid", obs_h1[10], 0);
        check("ramp_s_mid", obs_l1[10], 20 - 128);
        check("ramp_d_last", obs_h1[L/2-1], 1);
        check("ramp_s_last", obs_l1[L/2-1], 126);
        check("alt_d", obs_h2[64], -20);
        check("alt_s", obs_l2[64], 0);

        send_line(2, L, NEVER, NEVER);
        check("alt_d_first", obs_h1[0], -20);
        check("alt_s_first", obs_l1[0], 0);

        send_line(3, L, NEVER, NEVER);
        send_line(3, L, NEVER, NEVER);
        send_line(3, L + 6, NEVER, NEVER);
        check("overlength_pulses", pulses, L/2);

        send_line(3, 100, NEVER, NEVER);
        check("abort_pulses", pulses, 49);
        check("abort_line_err", int'(line_err), 1);
        send_line(3, L, NEVER, NEVER);
        check("after_abort_pulses", pulses, L/2);

        send_line(3, L, NEVER, 50);
        check("reset_clears_err", int'(line_err), 0);
        send_line(3, L, NEVER, NEVER);
        check("after_reset_pulses", pulses, L/2);

        send_line(3, L, 40, NEVER);
        check("tile_drop_pulses", pulses, 19);
        check("tile_drop_no_err", int'(line_err), 0);

        tile_pulses = 0;
        for (int k = 0; k < TL; k++) begin
            send_line(3, L, NEVER, NEVER);
            if (k == TL - 2) check("no_early_tile_done", tile_pulses, 0);
        end
        check("tile_done_count", tile_pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
